// File: rtl/led_frame_buffer_ctrl.sv
// led_frame_buffer_ctrl
//   Frame controller for the LED1 sample RAM. It captures DEPTH consecutive ADC
//   samples into a single-port RAM with a registered read address, then streams
//   the whole frame downstream, then returns to IDLE and refills if en is high.
//   This block owns every RAM port.
//
// Ports
//   clk, reset_n        clock (posedge) and asynchronous active-low reset
//   en                  run enable, looked at only in IDLE
//   in_data/in_valid    ADC sample strobe, no upstream backpressure
//   in_ready            high only while filling
//   ram_data/addr/we    RAM write data, address (read and write), write enable
//   ram_q               RAM read data for the address presented last cycle
//   out_data/valid/last downstream frame stream; last marks sample DEPTH-1
//   out_ready           downstream accept
//   frame_done          one-cycle pulse after the last sample is accepted
//   drop_cnt            saturating count of samples that arrived while not ready
//   dbg_state           current FSM state (IDLE=0, FILL=1, RD_ADDR=2, RD_DATA=3)
//
// Handshake: a transfer happens on a rising edge where out_valid and out_ready
// are both high. Once out_valid is raised, out_data and out_last stay constant
// until that transfer; out_valid never drops without a transfer.

module led_frame_buffer_ctrl #(
  parameter int DW    = 22,
  parameter int AW    = 11,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          frame_done,
  output logic [7:0]    drop_cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_RD_ADDR = 2'd2,
    S_RD_DATA = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW-1:0] rd_ptr, rd_ptr_d;
  // Set when the read address reached the RAM only this cycle, so ram_q still
  // holds the previous location and capture must wait one more clock.
  logic          rd_wait, rd_wait_d;

  logic          in_ready_d, ram_we_d, out_valid_d, out_last_d, frame_done_d;
  logic [DW-1:0] ram_data_d, out_data_d;
  logic [AW-1:0] ram_addr_d;
  logic [7:0]    drop_cnt_d;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_wait    <= 1'b0;
      in_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      rd_wait    <= rd_wait_d;
      in_ready   <= in_ready_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_data   <= ram_data_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
      frame_done <= frame_done_d;
      drop_cnt   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    rd_wait_d    = rd_wait;
    in_ready_d   = in_ready;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_data_d   = ram_data;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    out_last_d   = out_last;
    frame_done_d = 1'b0;
    drop_cnt_d   = drop_cnt;

    if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt_d = drop_cnt + 8'd1;
    end

    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_d    = S_FILL;
          in_ready_d = 1'b1;
          wr_ptr_d   = '0;
        end
      end

      S_FILL: begin
        if (in_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = wr_ptr;
          ram_data_d = in_data;
          wr_ptr_d   = wr_ptr + AW'(1);
          if (wr_ptr == LAST) begin
            in_ready_d = 1'b0;
            rd_ptr_d   = '0;
            state_d    = S_RD_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        ram_addr_d = rd_ptr;
        // Coming straight from the last write, the address switches only now;
        // coming from a transfer it was already preloaded last cycle.
        rd_wait_d  = ram_we;
        state_d    = S_RD_DATA;
      end

      S_RD_DATA: begin
        if (rd_wait) begin
          rd_wait_d = 1'b0;
        end else if (!out_valid) begin
          out_data_d  = ram_q;
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr == LAST);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (rd_ptr != LAST) begin
            rd_ptr_d   = rd_ptr + AW'(1);
            ram_addr_d = rd_ptr + AW'(1);
            state_d    = S_RD_ADDR;
          end else begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_frame_buffer_ctrl.sv
// Bench for led_frame_buffer_ctrl with a small frame (DEPTH=8) and a behavioural
// RAM whose read data is registered from the address of the previous cycle.

module tb_led_frame_buffer_ctrl;

  localparam int DW    = 22;
  localparam int AW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_done;
  logic [7:0]    drop_cnt;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]    exp_q[$];
  logic [AW+DW-1:0] wr_q[$];

  logic [DW-1:0] mem [2**AW];

  typedef struct {
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int            stall_idx;
    int            stall_len;
    int            strobes;
    bit            rand_bp;
    logic [7:0]    exp_drop;
  } vec_t;

  vec_t rows [6];

  led_frame_buffer_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check any RAM write visible there.
  task automatic tick();
    logic [AW+DW-1:0] w;
    @(negedge clk);
    if (reset_n && ram_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_ram_we", 64'(ram_we), 64'd0);
      end else begin
        w = wr_q.pop_front();
        check("ram_write", 64'({ram_addr, ram_data}), 64'(w));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({in_ready, ram_we, out_valid, out_last, frame_done,
                     ram_addr, ram_data, out_data, drop_cnt, dbg_state}), 64'd0);
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("fill_wait_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Drives DEPTH back-to-back samples; leaves in_valid high at the next negedge.
  task automatic fill_frame(input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [DW-1:0] d;
    wait_in_ready();
    d = base;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back(d);
      wr_q.push_back({AW'(i), d});
      tick();
      d = d + step;
    end
  endtask

  task automatic read_frame(input vec_t r);
    int got = 0;
    int cyc = 0;
    int first_cyc = -1;
    int stalled = 0;
    int sent = 0;
    logic [DW-1:0] e;
    while (got < DEPTH && cyc < 2000) begin
      cyc++;
      if (sent < r.strobes) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && got == r.stall_idx && stalled < r.stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (r.rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 64'(out_valid), 64'd0);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0]));
          check("out_last", 64'(out_last), 64'(got == DEPTH - 1));
          if (out_ready) begin
            e = exp_q.pop_front();
            got++;
          end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    check("read_complete", 64'(got), 64'(DEPTH));
    check("first_valid_latency", 64'(first_cyc), 64'd4);
    check("frame_done_pulse", 64'(frame_done), 64'd1);
    check("drop_cnt", 64'(drop_cnt), 64'(r.exp_drop));
    tick();
    check("frame_done_single", 64'(frame_done), 64'd0);
    check("queues_empty", 64'(exp_q.size() + wr_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rows[0] = '{22'h000000, 22'h000001, -1, 0,   0,   1'b0, 8'd0};
    rows[1] = '{22'h3FFFF8, 22'h000001, -1, 0,   0,   1'b0, 8'd0};
    rows[2] = '{22'h155555, 22'h02AAAB,  3, 5,   10,  1'b0, 8'd10};
    rows[3] = '{22'h2ABCDE, 22'h3FFFFF,  5, 300, 300, 1'b0, 8'd255};
    rows[4] = '{22'h000001, 22'h000002, -1, 0,   7,   1'b1, 8'd255};
    rows[5] = '{DW'($urandom), DW'($urandom), -1, 0, 0, 1'b1, 8'd255};

    reset_n   = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    tick();

    // en low: samples are dropped, no writes, FSM stays idle
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      tick();
      in_valid = 1'b0;
      tick();
    end
    check("idle_drop_cnt", 64'(drop_cnt), 64'd10);
    check("idle_state", 64'(dbg_state), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // reset while the write of index 4 is in flight
    en = 1'b1;
    wait_in_ready();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(22'h100 + i);
      wr_q.push_back({AW'(i), DW'(22'h100 + i)});
      tick();
    end
    in_valid = 1'b0;
    check("fill_index4_state", 64'(dbg_state), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset_in_fill");
    exp_q.delete();
    wr_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;

    // reset while a sample is presented downstream
    fill_frame(22'h0ABCDE, 22'h000003);
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("rd_data_reached", 64'(out_valid), 64'd1);
    check("rd_data_first", 64'(out_data), 64'(exp_q[0]));
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset_in_rd_data");
    exp_q.delete();
    wr_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;

    // continuous frames with en held high
    for (int r = 0; r < 6; r++) begin
      fill_frame(rows[r].base, rows[r].step);
      read_frame(rows[r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
